// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, timer control bit positions and default base address
// shared by the GPIO/timer peripheral and its timer sub-block.
package mmio_pkg;
  localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_0000;
  localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
  localparam logic [3:0] OFF_TMR_CTRL = 4'h2;
  localparam logic [3:0] OFF_TMR_CMP  = 4'h3;
  localparam logic [3:0] OFF_TMR_CNT  = 4'h4;
  localparam logic [3:0] OFF_TMR_STAT = 4'h5;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  typedef enum logic {IDLE, RUN} tmr_state_t;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: compare timer with CTRL/CMP/CNT/STAT registers; EN is the FSM
// state itself, so RUN reads back as CTRL.EN=1.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  tmr_state_t state, state_n;
  logic auto_r, ie, match, hit;
  logic [31:0] cmp, cnt, cnt_n;
  logic we_ctrl, we_cmp, we_cnt, we_stat;
  assign we_ctrl = we && off == OFF_TMR_CTRL;
  assign we_cmp  = we && off == OFF_TMR_CMP;
  assign we_cnt  = we && off == OFF_TMR_CNT;
  assign we_stat = we && off == OFF_TMR_STAT;
  assign hit     = state == RUN && cnt == cmp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = we_ctrl ? (wdata[CTRL_EN] ? RUN : IDLE) : (hit && !auto_r) ? IDLE : state;
  // CPU writes to CNT beat the timer update; a match set beats write-1-to-clear
  always_comb begin
    cnt_n = we_cnt ? wdata : (state == RUN && !hit) ? cnt + 32'd1 : (hit && auto_r) ? '0 : cnt;
    irq   = match & ie;
    rdata = off == OFF_TMR_CTRL ? {29'b0, ie, auto_r, state == RUN} :
            off == OFF_TMR_CMP  ? cmp :
            off == OFF_TMR_CNT  ? cnt :
            off == OFF_TMR_STAT ? {31'b0, match} : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      auto_r <= 1'b0;
      ie     <= 1'b0;
      cmp    <= '0;
      cnt    <= '0;
      match  <= 1'b0;
    end else begin
      if (we_ctrl) begin
        auto_r <= wdata[CTRL_AUTO];
        ie     <= wdata[CTRL_IE];
      end
      if (we_cmp) cmp <= wdata;
      cnt   <= cnt_n;
      match <= hit | (match & !(we_stat & wdata[0]));
    end
endmodule

// File: rtl/mmio_gpio_timer.sv
// mmio_gpio_timer: 64-byte MMIO window with GPIO out/in registers and a compare
// timer that is built in only when MMIO_TIMER_EN is defined.
module mmio_gpio_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Write_Enable_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Sel_o,
  input  logic [7:0]  GPIO_i,
  output logic [7:0]  GPIO_o,
  output logic        Irq_o
);
  logic [3:0] off;
  logic we, unused;
  logic [7:0] gpio_out, sync1, sync2;
  logic [31:0] tmr_rdata;
  assign Sel_o  = Address_i[31:6] == BASE_ADDR[31:6];
  assign off    = Address_i[5:2];
  assign we     = Write_Enable_i & Sel_o;
  assign GPIO_o = gpio_out;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      if (we && off == OFF_GPIO_OUT) gpio_out <= Write_Data[7:0];
      sync1 <= GPIO_i;
      sync2 <= sync1;
    end
`ifdef MMIO_TIMER_EN
  mmio_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .off   (off),
    .wdata (Write_Data),
    .rdata (tmr_rdata),
    .irq   (Irq_o)
  );
  assign unused = ^Address_i[1:0];
`else
  assign tmr_rdata = '0;
  assign Irq_o     = 1'b0;
  assign unused    = ^{Address_i[1:0], Write_Data[31:8]};
`endif
  always_comb
    Read_Data = !Sel_o ? '0 :
                off == OFF_GPIO_OUT ? {24'b0, gpio_out} :
                off == OFF_GPIO_IN  ? {24'b0, sync2} : tmr_rdata;
endmodule

// File: tb/tb_mmio_gpio_timer.sv
// tb_mmio_gpio_timer: scoreboard bench for the GPIO/timer peripheral; timer
// scenarios run when MMIO_TIMER_EN is defined, absence checks otherwise.
module tb_mmio_gpio_timer;
  localparam logic [31:0] A_OUT  = 32'hFFFF_0000;
  localparam logic [31:0] A_IN   = 32'hFFFF_0004;
  localparam logic [31:0] A_CTRL = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0010;
  localparam logic [31:0] A_STAT = 32'hFFFF_0014;
  logic clk = 0, reset = 1, we = 0, sel, irq;
  logic [31:0] addr = 0, wd = 0, rdd;
  logic [7:0] gi = 0, go;
  logic [31:0] exp_q[$];
  logic [31:0] e, got;
  int checks = 0, failures = 0;

  mmio_gpio_timer dut (
    .clk(clk), .reset(reset), .Write_Enable_i(we), .Address_i(addr),
    .Write_Data(wd), .Read_Data(rdd), .Sel_o(sel), .GPIO_i(gi),
    .GPIO_o(go), .Irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1;
    @(posedge clk); #1;
    we = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; #1;
    d = rdd;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poll_cnt(input logic [31:0] v, output bit found);
    logic [31:0] r;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(A_CNT, r);
      if (r == v) found = 1;
      else cycles(1);
    end
  endtask

  task automatic test_reset;
    logic [31:0] al[4] = '{A_OUT, A_IN, A_CNT, A_STAT};
    #1 reset = 0;
    #1;
    exp_q.push_back(0);
    got = {24'b0, go}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_gpio_o: got %h expected %h", got, e); end
    exp_q.push_back(0);
    got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_irq: got %h expected %h", got, e); end
    foreach (al[i]) exp_q.push_back(0);
    foreach (al[i]) begin
      rd(al[i], got); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL reset_reg %h: got %h expected %h", al[i], got, e); end
    end
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_gpio_out;
    exp_q.push_back(32'hA5);
    wr(A_OUT, 32'h0000_01A5);
    got = {24'b0, go}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL gpio_o: got %h expected %h", got, e); end
    exp_q.push_back(32'h0000_00A5);
    rd(A_OUT, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL gpio_out_rd: got %h expected %h", got, e); end
    exp_q.push_back(1);
    got = {31'b0, sel}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL sel_base: got %h expected %h", got, e); end
  endtask

  task automatic test_gpio_in;
    logic [31:0] ev[4] = '{32'h0, 32'h0, 32'h3C, 32'h3C};
    gi = 8'h3C;
    foreach (ev[i]) exp_q.push_back(ev[i]);
    for (int i = 0; i < 4; i++) begin
      rd(A_IN, got); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL gpio_in edge%0d: got %h expected %h", i, got, e); end
      cycles(1);
    end
  endtask

`ifdef MMIO_TIMER_EN
  task automatic test_timer_auto;
    int c = 0;
    logic m = 0;
    wr(A_CMP, 5);
    wr(A_CNT, 0);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(c);
      exp_q.push_back({31'b0, m});
      rd(A_CNT, got); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL auto_cnt cyc%0d: got %h expected %h", i, got, e); end
      got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL auto_irq cyc%0d: got %h expected %h", i, got, e); end
      cycles(1);
      if (c == 5) begin m = 1; c = 0; end
      else c++;
    end
  endtask

  task automatic test_w1c;
    bit found;
    poll_cnt(2, found);
    checks++;
    if (!found) begin failures++; $display("FAIL poll_cnt2: got timeout expected 2"); end
    wr(A_STAT, 1);
    exp_q.push_back(0);
    rd(A_STAT, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL w1c_clear: got %h expected %h", got, e); end
    poll_cnt(5, found);
    checks++;
    if (!found) begin failures++; $display("FAIL poll_cnt5: got timeout expected 5"); end
    wr(A_STAT, 1);
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(0);
    rd(A_STAT, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL set_beats_clr: got %h expected %h", got, e); end
    got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL set_beats_clr_irq: got %h expected %h", got, e); end
    rd(A_CNT, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reload_cnt: got %h expected %h", got, e); end
    poll_cnt(2, found);
    checks++;
    if (!found) begin failures++; $display("FAIL poll_cnt2b: got timeout expected 2"); end
    wr(A_STAT, 1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    rd(A_STAT, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL later_clr: got %h expected %h", got, e); end
    got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL later_clr_irq: got %h expected %h", got, e); end
    wr(A_CTRL, 0);
  endtask

  task automatic test_oneshot;
    logic [31:0] al[3] = '{A_STAT, A_CTRL, A_CNT};
    wr(A_CMP, 3);
    wr(A_CNT, 0);
    wr(A_CTRL, 32'h1);
    cycles(3);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    foreach (al[i]) begin
      rd(al[i], got); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL oneshot_pre %h: got %h expected %h", al[i], got, e); end
    end
    cycles(1);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(3);
    foreach (al[i]) begin
      rd(al[i], got); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL oneshot_hit %h: got %h expected %h", al[i], got, e); end
    end
    exp_q.push_back(0);
    got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL oneshot_irq_ie0: got %h expected %h", got, e); end
    cycles(5);
    exp_q.push_back(3);
    rd(A_CNT, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL oneshot_hold: got %h expected %h", got, e); end
  endtask
`else
  task automatic test_no_timer;
    logic [31:0] al[4] = '{A_CTRL, A_CMP, A_CNT, A_STAT};
    wr(A_CMP, 5);
    wr(A_CNT, 9);
    wr(A_CTRL, 32'h7);
    cycles(10);
    foreach (al[i]) exp_q.push_back(0);
    foreach (al[i]) begin
      rd(al[i], got); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL no_timer %h: got %h expected %h", al[i], got, e); end
    end
    exp_q.push_back(0);
    got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL no_timer_irq: got %h expected %h", got, e); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] al[5] = '{A_OUT, A_CTRL, A_CMP, A_CNT, A_STAT};
    wr(A_OUT, 32'h5A);
`ifdef MMIO_TIMER_EN
    begin
      bit found;
      wr(A_CMP, 100);
      wr(A_CNT, 0);
      wr(A_CTRL, 32'h5);
      poll_cnt(7, found);
      checks++;
      if (!found) begin failures++; $display("FAIL poll_cnt7: got timeout expected 7"); end
      exp_q.push_back(1);
      got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL pre_reset_irq: got %h expected %h", got, e); end
    end
`endif
    reset = 0;
    #1;
    exp_q.push_back(0); exp_q.push_back(0);
    got = {24'b0, go}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL mid_reset_gpio_o: got %h expected %h", got, e); end
    got = {31'b0, irq}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL mid_reset_irq: got %h expected %h", got, e); end
    foreach (al[i]) exp_q.push_back(0);
    foreach (al[i]) begin
      rd(al[i], got); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL mid_reset %h: got %h expected %h", al[i], got, e); end
    end
    reset = 1;
    cycles(4);
    exp_q.push_back(0); exp_q.push_back(0);
    rd(A_CNT, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL cnt_abandoned: got %h expected %h", got, e); end
    rd(A_CTRL, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL ctrl_after_reset: got %h expected %h", got, e); end
  endtask

  task automatic test_unselected;
    wr(A_OUT, 32'h5A);
    wr(32'h1001_0000, 32'h77);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(32'h5A);
    rd(32'h1001_0000, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL unsel_rd: got %h expected %h", got, e); end
    got = {31'b0, sel}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL unsel_sel: got %h expected %h", got, e); end
    got = {24'b0, go}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL unsel_wr_ignored: got %h expected %h", got, e); end
    exp_q.push_back(0);
    rd(32'hFFFF_0018, got); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL unmapped_rd: got %h expected %h", got, e); end
  endtask

  initial begin
    test_reset;
    test_gpio_out;
    test_gpio_in;
`ifdef MMIO_TIMER_EN
    test_timer_auto;
    test_w1c;
    test_oneshot;
`else
    test_no_timer;
`endif
    test_reset_mid;
    test_unselected;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_gpio_timer.md
MMIO_GPIO_TIMER -- requirements
Module: mmio_gpio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, word-aligned base of the 64-byte register window.
REQ-002 SHALL have port clk  input  1  single clock; all flops update on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Write_Enable_i  input  1  CPU store strobe, sampled on the rising clk edge.
REQ-005 SHALL have port Address_i  input  32  CPU byte address; bits [1:0] ignored.
REQ-006 SHALL have port Write_Data  input  32  CPU store data.
REQ-007 SHALL have port Read_Data  output  32  register read data.
REQ-008 SHALL have port Sel_o  output  1  high when Address_i[31:6] == BASE_ADDR[31:6]; selects this block in the top-level read mux.
REQ-009 SHALL have port GPIO_i  input  8  asynchronous external inputs.
REQ-010 SHALL have port GPIO_o  output  8  output register value.
REQ-011 SHALL have port Irq_o  output  1  timer interrupt request, level-sensitive.

Function
REQ-012 SHALL decode word offset Address_i[5:2] only while Sel_o=1; a write takes effect on the rising clk edge when Write_Enable_i=1 and Sel_o=1.
REQ-013 SHALL drive Read_Data combinationally, with zero latency, from the current offset; unmapped offsets and Sel_o=0 read 0.
REQ-014 SHALL implement this map: 0x00 GPIO_OUT RW[7:0]; 0x04 GPIO_IN RO[7:0]; 0x08 TMR_CTRL RW[2:0] (bit0 EN, bit1 AUTO, bit2 IE); 0x0C TMR_CMP RW[31:0]; 0x10 TMR_CNT RW[31:0]; 0x14 TMR_STAT bit0 MATCH, write-1-to-clear.
REQ-015 SHALL write GPIO_OUT from Write_Data[7:0] and drive GPIO_o directly from GPIO_OUT; upper write bits are discarded.
REQ-016 SHALL pass GPIO_i through a two-flop synchronizer, so that GPIO_IN reflects a pin change 2 cycles later.
REQ-017 SHALL operate the timer as an FSM with states IDLE (EN=0, count holds) and RUN (EN=1, count increments by 1 per cycle).
REQ-018 SHALL, in RUN when TMR_CNT == TMR_CMP, set MATCH on the next edge; if AUTO=1, load TMR_CNT with 0 and stay in RUN; if AUTO=0, hold the count and clear EN (one-shot back to IDLE).
REQ-019 SHALL wrap TMR_CNT from 32'hFFFF_FFFF to 0 without setting MATCH unless TMR_CMP matches.
REQ-020 SHALL give a CPU write to TMR_CNT or TMR_CTRL priority over the timer update in the same cycle.
REQ-021 SHALL let a MATCH set win over a simultaneous write-1-to-clear.
REQ-022 SHALL drive Irq_o = MATCH & IE.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear GPIO_OUT, both synchronizer stages, TMR_CTRL, TMR_CMP, TMR_CNT and MATCH, giving GPIO_o=0 and Irq_o=0.
REQ-024 SHALL, on reset mid-count, abandon the count; the timer resumes only after software sets EN again.

Configuration
REQ-025 SHALL compile the timer in when macro MMIO_TIMER_EN is defined.
REQ-026 SHALL, when MMIO_TIMER_EN is undefined, contain no timer logic: offsets 0x08-0x14 read 0, writes to them are ignored, and Irq_o is tied to 0; GPIO behaviour is unchanged.

Structure
REQ-027 SHALL keep register offsets, TMR_CTRL bit indices and the default BASE_ADDR in shared package mmio_pkg.
REQ-028 SHALL implement the timer (CTRL/CMP/CNT/STAT and FSM) as sub-module mmio_timer, instantiated only under MMIO_TIMER_EN.

Verification
REQ-029 SHALL cover: store 32'h0000_01A5 to 0xFFFF0000 -> GPIO_o=8'hA5 after the edge, and a load of 0xFFFF0000 returns 32'h0000_00A5.
REQ-030 SHALL cover: set GPIO_i=8'h3C -> a read of 0xFFFF0004 returns 8'h3C from the 2nd edge onward and the old value before it.
REQ-031 SHALL cover: CMP=5, CNT=0, CTRL=3'b111 -> MATCH and Irq_o rise after count 5, CNT reloads to 0, and the match repeats every 6 cycles.
REQ-032 SHALL cover: CTRL=3'b001, CMP=3 -> one-shot: MATCH set, EN reads 0, and CNT holds 3 with no further change.
REQ-033 SHALL cover: write 1 to TMR_STAT in the same cycle a new match occurs -> MATCH remains 1; a later write 1 with no match clears it and drops Irq_o.
REQ-034 SHALL cover: reset pulsed low mid-count at CNT=7 -> all registers read 0 immediately, GPIO_o=0, and Irq_o=0; Address_i=0x1001_0000 -> Sel_o=0 and Read_Data=0.
